// File: rtl/led_fifo_if.sv
// TX FIFO write port between the frame packer and the LED PHY FIFO.
interface led_fifo_if #(
  parameter int COLOR_W = 4
) ();
  logic                   we;
  logic [3*COLOR_W-1:0]   fifo_data;
  logic                   fifo_full;

  modport master (
    output we,
    output fifo_data,
    input  fifo_full
  );

  modport slave (
    input  we,
    input  fifo_data,
    output fifo_full
  );
endinterface

// File: rtl/led_frame_packer.sv
// Builds one LED frame from zone colour snapshots and a programmable
// segment map, streaming scaled RGB words into the PHY TX FIFO.
module led_frame_packer #(
  parameter int NUM_ZONES = 8,
  parameter int COLOR_W   = 4,
  parameter int MAX_SEGS  = 16,
  parameter int SEG_LEN_W = 4,
  parameter int BRIGHT_W  = 4,
  parameter int LED_CNT_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arm,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_ZONES*COLOR_W-1:0]   zone_r,
  input  logic [NUM_ZONES*COLOR_W-1:0]   zone_g,
  input  logic [NUM_ZONES*COLOR_W-1:0]   zone_b,
  input  logic [BRIGHT_W-1:0]            brightness,
  input  logic [$clog2(MAX_SEGS+1)-1:0]  num_segs,
  input  logic                           cfg_we,
  input  logic [$clog2(MAX_SEGS)-1:0]    cfg_idx,
  input  logic [$clog2(NUM_ZONES)-1:0]   cfg_zone,
  input  logic [SEG_LEN_W-1:0]           cfg_len,
  led_fifo_if.master                     fifo,
  output logic                           send_start,
  output logic                           busy,
  output logic [LED_CNT_W-1:0]           leds_written,
  output logic                           cfg_err
);

  localparam int NS_W = $clog2(MAX_SEGS+1);
  localparam int IX_W = $clog2(MAX_SEGS);
  localparam int ZW   = $clog2(NUM_ZONES);
  localparam int ZB   = NUM_ZONES*COLOR_W;
  localparam int PW   = COLOR_W+BRIGHT_W;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_LOAD, S_WRITE, S_DONE
  } state_t;

  state_t state, nxt;

  logic [ZW-1:0]        seg_zone [MAX_SEGS];
  logic [SEG_LEN_W-1:0] seg_len  [MAX_SEGS];

  logic [ZB-1:0]        snap_r, snap_g, snap_b;
  logic [BRIGHT_W-1:0]  bright_q;
  logic [NS_W-1:0]      nsegs_q, nsegs_in;
  logic [NS_W-1:0]      seg_idx;
  logic [SEG_LEN_W-1:0] led_idx;

  logic [ZW-1:0]        cur_zone;
  logic [SEG_LEN_W-1:0] cur_len;
  logic                 we_c, adv, last_seg;

  // (c * (b+1)) >> BRIGHT_W; the product never exceeds PW bits
  function automatic logic [COLOR_W-1:0] scale(
    input logic [COLOR_W-1:0]  c,
    input logic [BRIGHT_W-1:0] b
  );
    logic [BRIGHT_W:0] m;
    logic [PW-1:0]     p;
    m = {1'b0, b} + {{BRIGHT_W{1'b0}}, 1'b1};
    p = PW'(c) * PW'(m);
    return p[BRIGHT_W +: COLOR_W];
  endfunction

  assign nsegs_in = (num_segs > NS_W'(MAX_SEGS)) ?
                    NS_W'(MAX_SEGS) : num_segs;
  assign cur_zone = seg_zone[seg_idx[IX_W-1:0]];
  assign cur_len  = seg_len[seg_idx[IX_W-1:0]];
  assign last_seg = (seg_idx == nsegs_q - NS_W'(1));

  assign busy = (state == S_LOAD) || (state == S_WRITE) ||
                (state == S_DONE);
  assign send_start = (state == S_DONE) && !abort;

  assign fifo.we = we_c;
  assign fifo.fifo_data = we_c ? {
    scale(snap_r[cur_zone*COLOR_W +: COLOR_W], bright_q),
    scale(snap_g[cur_zone*COLOR_W +: COLOR_W], bright_q),
    scale(snap_b[cur_zone*COLOR_W +: COLOR_W], bright_q)
  } : '0;

  always_comb begin
    nxt  = state;
    we_c = 1'b0;
    adv  = 1'b0;
    unique case (state)
      S_IDLE:  if (arm) nxt = S_ARMED;
      S_ARMED: if (start) nxt = S_LOAD;
      S_LOAD:  nxt = (nsegs_in != '0) ? S_WRITE : S_DONE;
      S_WRITE: begin
        if (cur_len == '0) begin
          adv = 1'b1;
        end else if (!fifo.fifo_full) begin
          we_c = 1'b1;
          adv  = (led_idx == cur_len - SEG_LEN_W'(1));
        end
        if (adv && last_seg) nxt = S_DONE;
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    // abort wins over every transition and suppresses the write
    if (abort && state != S_IDLE) begin
      nxt  = S_IDLE;
      we_c = 1'b0;
      adv  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      for (int i = 0; i < MAX_SEGS; i++) begin
        seg_zone[i] <= '0;
        seg_len[i]  <= '0;
      end
      snap_r       <= '0;
      snap_g       <= '0;
      snap_b       <= '0;
      bright_q     <= '0;
      nsegs_q      <= '0;
      seg_idx      <= '0;
      led_idx      <= '0;
      leds_written <= '0;
      cfg_err      <= 1'b0;
    end else begin
      state   <= nxt;
      cfg_err <= cfg_we && busy;
      if (cfg_we && !busy) begin
        seg_zone[cfg_idx] <= cfg_zone;
        seg_len[cfg_idx]  <= cfg_len;
      end
      if (state == S_LOAD && !abort) begin
        snap_r       <= zone_r;
        snap_g       <= zone_g;
        snap_b       <= zone_b;
        bright_q     <= brightness;
        nsegs_q      <= nsegs_in;
        seg_idx      <= '0;
        led_idx      <= '0;
        leds_written <= '0;
      end
      if (adv) begin
        seg_idx <= seg_idx + NS_W'(1);
        led_idx <= '0;
      end else if (we_c) begin
        led_idx <= led_idx + SEG_LEN_W'(1);
      end
      if (we_c && leds_written != '1)
        leds_written <= leds_written + LED_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_led_frame_packer.sv
// Directed bench for led_frame_packer: legacy map, backpressure,
// zero-length entries, brightness, abort/snapshot and config guard.
module tb_led_frame_packer;

  logic        clk = 1'b0;
  logic        rst, arm, start, abort;
  logic [31:0] zone_r, zone_g, zone_b;
  logic [3:0]  brightness;
  logic [4:0]  num_segs;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [2:0]  cfg_zone;
  logic [3:0]  cfg_len;
  logic        send_start, busy, cfg_err;
  logic [7:0]  leds_written;

  led_fifo_if #(.COLOR_W(4)) fifo ();

  led_frame_packer dut (
    .clk(clk), .rst(rst), .arm(arm), .start(start), .abort(abort),
    .zone_r(zone_r), .zone_g(zone_g), .zone_b(zone_b),
    .brightness(brightness), .num_segs(num_segs),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_zone(cfg_zone),
    .cfg_len(cfg_len), .fifo(fifo.master),
    .send_start(send_start), .busy(busy),
    .leds_written(leds_written), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] wr_data [$];
  int          wr_cyc  [$];
  int          ss_cnt, ss_cyc, err_cnt, err_cyc, bad_full;

  int lz [12] = '{7, 6, 5, 5, 3, 0, 0, 1, 2, 2, 4, 7};
  int ll [12] = '{4, 4, 4, 1, 4, 1, 4, 4, 4, 1, 4, 1};
  logic [11:0] legacy [$];

  task automatic cfg_write(input int idx, input int z, input int len);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 4'(idx);
    cfg_zone = 3'(z); cfg_len = 4'(len);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic set_zones_k();
    for (int k = 0; k < 8; k++) begin
      zone_r[k*4 +: 4] = 4'(k);
      zone_g[k*4 +: 4] = 4'(k);
      zone_b[k*4 +: 4] = 4'(k);
    end
  endtask

  task automatic program_legacy();
    for (int e = 0; e < 12; e++) cfg_write(e, lz[e], ll[e]);
    set_zones_k();
    brightness = 4'hF;
    num_segs   = 5'd12;
  endtask

  // arm, start in cycle 0, then capture cycles 1..ncyc
  task automatic run_frame(input int ncyc, input int full_c,
                           input int full_n, input int abort_c,
                           input int poke_c, input int cfg_c);
    wr_data.delete(); wr_cyc.delete();
    ss_cnt = 0; ss_cyc = -1; err_cnt = 0; err_cyc = -1;
    bad_full = 0;
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      fifo.fifo_full = (c >= full_c) && (c < full_c + full_n);
      abort  = (c == abort_c);
      cfg_we = (c == cfg_c);
      if (c == poke_c) zone_r = '1;
      #1;
      if (fifo.we) begin
        wr_data.push_back(fifo.fifo_data);
        wr_cyc.push_back(c);
        if (fifo.fifo_full) bad_full++;
      end
      if (send_start) begin ss_cnt++; ss_cyc = c; end
      if (cfg_err) begin err_cnt++; err_cyc = c; end
    end
    fifo.fifo_full = 1'b0; abort = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp += 5;
    if (fifo.we !== 1'b0) begin n_bad++;
      $display("FAIL reset_we got %b want 0", fifo.we); end
    if (send_start !== 1'b0) begin n_bad++;
      $display("FAIL reset_ss got %b want 0", send_start); end
    if (busy !== 1'b0) begin n_bad++;
      $display("FAIL reset_busy got %b want 0", busy); end
    if (cfg_err !== 1'b0) begin n_bad++;
      $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
    if (leds_written !== 8'd0) begin n_bad++;
      $display("FAIL reset_leds got %0d want 0", leds_written); end
    // cleared table: two zero-length entries, skipped in two cycles
    num_segs = 5'd2;
    run_frame(8, -1, 0, -1, -1, -1);
    n_cmp += 2;
    if (wr_data.size() !== 0) begin n_bad++;
      $display("FAIL reset_table_writes got %0d want 0", wr_data.size()); end
    if (ss_cyc !== 4) begin n_bad++;
      $display("FAIL reset_table_ss got %0d want 4", ss_cyc); end
  endtask

  task automatic test_legacy();
    program_legacy();
    run_frame(40, -1, 0, -1, -1, -1);
    n_cmp++;
    if (wr_data.size() !== 36) begin n_bad++;
      $display("FAIL legacy_count got %0d want 36", wr_data.size()); end
    for (int i = 0; i < 36 && i < wr_data.size(); i++) begin
      n_cmp += 2;
      if (wr_data[i] !== legacy[i]) begin n_bad++;
        $display("FAIL legacy_data[%0d] got %h want %h", i, wr_data[i], legacy[i]); end
      if (wr_cyc[i] !== i + 2) begin n_bad++;
        $display("FAIL legacy_cyc[%0d] got %0d want %0d", i, wr_cyc[i], i + 2); end
    end
    n_cmp += 3;
    if (ss_cyc !== 38 || ss_cnt !== 1) begin n_bad++;
      $display("FAIL legacy_ss got cyc %0d cnt %0d want 38/1", ss_cyc, ss_cnt); end
    if (leds_written !== 8'd36) begin n_bad++;
      $display("FAIL legacy_leds got %0d want 36", leds_written); end
    if (busy !== 1'b0) begin n_bad++;
      $display("FAIL legacy_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    run_frame(44, 6, 3, -1, -1, -1);
    n_cmp += 2;
    if (wr_data.size() !== 36) begin n_bad++;
      $display("FAIL bp_count got %0d want 36", wr_data.size()); end
    if (bad_full !== 0) begin n_bad++;
      $display("FAIL bp_we_while_full got %0d want 0", bad_full); end
    for (int i = 0; i < 36 && i < wr_data.size(); i++) begin
      n_cmp += 2;
      if (wr_data[i] !== legacy[i]) begin n_bad++;
        $display("FAIL bp_data[%0d] got %h want %h", i, wr_data[i], legacy[i]); end
      if (wr_cyc[i] !== ((i < 4) ? i + 2 : i + 5)) begin n_bad++;
        $display("FAIL bp_cyc[%0d] got %0d want %0d", i, wr_cyc[i], (i < 4) ? i + 2 : i + 5); end
    end
    n_cmp++;
    if (ss_cyc !== 41 || ss_cnt !== 1) begin n_bad++;
      $display("FAIL bp_ss got cyc %0d cnt %0d want 41/1", ss_cyc, ss_cnt); end
  endtask

  task automatic test_zero_len();
    cfg_write(0, 0, 0);
    cfg_write(1, 3, 2);
    cfg_write(2, 5, 0);
    num_segs = 5'd3;
    run_frame(9, -1, 0, -1, -1, -1);
    n_cmp += 2;
    if (wr_data.size() !== 2) begin n_bad++;
      $display("FAIL zl_count got %0d want 2", wr_data.size()); end
    if (ss_cyc !== 6 || ss_cnt !== 1) begin n_bad++;
      $display("FAIL zl_ss got cyc %0d cnt %0d want 6/1", ss_cyc, ss_cnt); end
    for (int i = 0; i < wr_data.size(); i++) begin
      n_cmp++;
      if (wr_data[i] !== 12'h333) begin n_bad++;
        $display("FAIL zl_data[%0d] got %h want 333", i, wr_data[i]); end
    end
    num_segs = 5'd0;
    run_frame(5, -1, 0, -1, -1, -1);
    n_cmp += 2;
    if (wr_data.size() !== 0) begin n_bad++;
      $display("FAIL zero_segs_count got %0d want 0", wr_data.size()); end
    if (ss_cyc !== 2 || ss_cnt !== 1) begin n_bad++;
      $display("FAIL zero_segs_ss got cyc %0d cnt %0d want 2/1", ss_cyc, ss_cnt); end
  endtask

  task automatic test_brightness();
    cfg_write(0, 2, 1);
    num_segs = 5'd1;
    zone_r[8 +: 4] = 4'hF;
    zone_g[8 +: 4] = 4'h8;
    zone_b[8 +: 4] = 4'h4;
    brightness = 4'd7;
    run_frame(5, -1, 0, -1, -1, -1);
    n_cmp += 2;
    if (wr_data.size() !== 1) begin n_bad++;
      $display("FAIL bright7_count got %0d want 1", wr_data.size()); end
    else if (wr_data[0] !== 12'h742) begin n_bad++;
      $display("FAIL bright7_data got %h want 742", wr_data[0]); end
    if (ss_cyc !== 3) begin n_bad++;
      $display("FAIL bright7_ss got %0d want 3", ss_cyc); end
    brightness = 4'd0;
    run_frame(5, -1, 0, -1, -1, -1);
    n_cmp++;
    if (wr_data.size() !== 1) begin n_bad++;
      $display("FAIL bright0_count got %0d want 1", wr_data.size()); end
    else if (wr_data[0] !== 12'h000) begin n_bad++;
      $display("FAIL bright0_data got %h want 000", wr_data[0]); end
  endtask

  task automatic test_abort_snapshot();
    program_legacy();
    run_frame(16, -1, 0, 12, 5, -1);
    n_cmp += 4;
    if (wr_data.size() !== 10) begin n_bad++;
      $display("FAIL abort_count got %0d want 10", wr_data.size()); end
    if (ss_cnt !== 0) begin n_bad++;
      $display("FAIL abort_ss got %0d want 0", ss_cnt); end
    if (leds_written !== 8'd10) begin n_bad++;
      $display("FAIL abort_leds got %0d want 10", leds_written); end
    if (busy !== 1'b0) begin n_bad++;
      $display("FAIL abort_busy got %b want 0", busy); end
    for (int i = 0; i < 10 && i < wr_data.size(); i++) begin
      n_cmp++;
      if (wr_data[i] !== legacy[i]) begin n_bad++;
        $display("FAIL snap_data[%0d] got %h want %h", i, wr_data[i], legacy[i]); end
    end
    // back in IDLE: a bare start must not launch a frame
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    n_cmp += 2;
    if (busy !== 1'b0) begin n_bad++;
      $display("FAIL idle_start_busy got %b want 0", busy); end
    if (leds_written !== 8'd10) begin n_bad++;
      $display("FAIL abort_leds_hold got %0d want 10", leds_written); end
    set_zones_k();
    run_frame(40, -1, 0, -1, -1, -1);
    n_cmp += 2;
    if (wr_data.size() !== 36 || ss_cyc !== 38) begin n_bad++;
      $display("FAIL rerun got count %0d ss %0d want 36/38", wr_data.size(), ss_cyc); end
    if (wr_data.size() > 0 && wr_data[0] !== 12'h777) begin n_bad++;
      $display("FAIL rerun_first got %h want 777", wr_data[0]); end
  endtask

  task automatic test_config_busy();
    program_legacy();
    cfg_idx = 4'd0; cfg_zone = 3'd4; cfg_len = 4'd2;
    run_frame(40, -1, 0, -1, -1, 5);
    n_cmp += 2;
    if (err_cnt !== 1 || err_cyc !== 6) begin n_bad++;
      $display("FAIL cfg_err_pulse got cnt %0d cyc %0d want 1/6", err_cnt, err_cyc); end
    if (wr_data.size() !== 36) begin n_bad++;
      $display("FAIL cfg_busy_count got %0d want 36", wr_data.size()); end
    run_frame(40, -1, 0, -1, -1, -1);
    n_cmp++;
    if (wr_data.size() !== 36) begin n_bad++;
      $display("FAIL readback_count got %0d want 36", wr_data.size()); end
    for (int i = 0; i < 36 && i < wr_data.size(); i++) begin
      n_cmp++;
      if (wr_data[i] !== legacy[i]) begin n_bad++;
        $display("FAIL readback_data[%0d] got %h want %h", i, wr_data[i], legacy[i]); end
    end
    cfg_write(0, 4, 2);
    #1;
    n_cmp++;
    if (cfg_err !== 1'b0) begin n_bad++;
      $display("FAIL idle_cfg_err got %b want 0", cfg_err); end
    run_frame(40, -1, 0, -1, -1, -1);
    n_cmp += 2;
    if (wr_data.size() !== 34 || ss_cyc !== 36) begin n_bad++;
      $display("FAIL idle_cfg_frame got count %0d ss %0d want 34/36", wr_data.size(), ss_cyc); end
    if (wr_data.size() < 3 || wr_data[0] !== 12'h444 ||
        wr_data[1] !== 12'h444 || wr_data[2] !== 12'h666) begin n_bad++;
      $display("FAIL idle_cfg_data got %h %h %h want 444 444 666",
               wr_data.size() > 0 ? wr_data[0] : 12'hxxx,
               wr_data.size() > 1 ? wr_data[1] : 12'hxxx,
               wr_data.size() > 2 ? wr_data[2] : 12'hxxx); end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; start = 1'b0; abort = 1'b0;
    zone_r = '0; zone_g = '0; zone_b = '0;
    brightness = '0; num_segs = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_zone = '0; cfg_len = '0;
    fifo.fifo_full = 1'b0;
    for (int e = 0; e < 12; e++)
      for (int j = 0; j < ll[e]; j++)
        legacy.push_back({4'(lz[e]), 4'(lz[e]), 4'(lz[e])});
    test_reset();
    test_legacy();
    test_backpressure();
    test_zero_len();
    test_brightness();
    test_abort_snapshot();
    test_config_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
